quad4_grad_engine: RTL and testbench

//  Responder side of the start_func/func_done evaluation handshake driven by the gradient-descent controller.
//  Per request: evaluates f = sum (x_i - T_i)^2 over x = {a,b,c,d}, and step_i = LR * 2*(x_i - T_i).
//  The controller computes x_next = x - step.
//  One shared signed multiplier is time-multiplexed over 8 products (4 squares, 4 steps).

---
 rtl/quad4_grad_engine.sv | 143 ++++++++++++++
 tb/tb_quad4_grad_engine.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/quad4_grad_engine.sv
// +----------------------------------------------------------------------------+
// | quad4_grad_engine: quadratic cost f(x) and scaled gradient step for 4 vars |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module quad4_grad_engine #(
  parameter logic signed [31:0] LEARNING_RATE = 32'h0000_0030,
  parameter logic [15:0]        A_T           = 16'h0100,
  parameter logic [15:0]        B_T           = 16'hFE00,
  parameter logic [15:0]        C_T           = 16'h0080,
  parameter logic [15:0]        D_T           = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_func,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  input  logic [15:0] c_in,
  input  logic [15:0] d_in,
  output logic [31:0] value,
  output logic [15:0] a_diff_out,
  output logic [15:0] b_diff_out,
  output logic [15:0] c_diff_out,
  output logic [15:0] d_diff_out,
  output logic        func_done,
  output logic        overflow
);

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_LOAD = 2'd1;
  localparam logic [1:0]  S_MUL  = 2'd2;
  localparam logic [1:0]  S_FIN  = 2'd3;
  localparam logic [63:0] C_TGT  = {D_T, C_T, B_T, A_T};

  logic [1:0]         r_state;
  logic               r_start_q;
  logic [2:0]         r_cnt;
  logic signed [35:0] r_acc;
  logic signed [15:0] r_x [4];
  logic signed [16:0] r_e [4];
  logic signed [33:0] r_p [4];

  logic               w_accept;
  logic signed [16:0] w_e_sel;
  logic signed [31:0] w_mul_a;
  logic signed [17:0] w_mul_b;
  logic signed [49:0] w_prod;
  logic signed [35:0] w_sq;
  logic signed [33:0] w_step;
  logic [13:0]        w_unused_prod;
  logic               w_val_ov;
  logic [31:0]        w_val_sat;
  logic [3:0]         w_diff_ov;
  logic [15:0]        w_diff_sat [4];

  assign w_accept = (r_state == S_IDLE) && start_func && !r_start_q;

  // cnt[2]=0: e*e (square); cnt[2]=1: LR*(2e) (step). Same multiplier for both.
  assign w_e_sel = r_e[r_cnt[1:0]];
  assign w_mul_a = r_cnt[2] ? LEARNING_RATE : {{15{w_e_sel[16]}}, w_e_sel};
  assign w_mul_b = r_cnt[2] ? {w_e_sel, 1'b0} : {w_e_sel[16], w_e_sel};
  assign w_prod  = 50'(w_mul_a) * 50'(w_mul_b);

  // Bit-slicing above position 8 is the arithmetic >>>8 followed by truncation.
  assign w_sq          = w_prod[43:8];
  assign w_step        = w_prod[41:8];
  assign w_unused_prod = {w_prod[49:44], w_prod[7:0]};

  assign w_val_ov  = !((&r_acc[35:31]) || !(|r_acc[35:31]));
  assign w_val_sat = w_val_ov ? (r_acc[35] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                              : r_acc[31:0];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_diff_ov[gi]  = !((&r_p[gi][33:15]) || !(|r_p[gi][33:15]));
    assign w_diff_sat[gi] = w_diff_ov[gi] ? (r_p[gi][33] ? 16'h8000 : 16'h7FFF)
                                          : r_p[gi][15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_start_q  <= 1'b0;
      r_cnt      <= 3'd0;
      r_acc      <= '0;
      for (int i = 0; i < 4; i++) begin
        r_x[i] <= '0;
        r_e[i] <= '0;
        r_p[i] <= '0;
      end
      value      <= '0;
      a_diff_out <= '0;
      b_diff_out <= '0;
      c_diff_out <= '0;
      d_diff_out <= '0;
      func_done  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      r_start_q <= start_func;
      func_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x[0]  <= a_in;
            r_x[1]  <= b_in;
            r_x[2]  <= c_in;
            r_x[3]  <= d_in;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          for (int i = 0; i < 4; i++) begin
            r_e[i] <= {r_x[i][15], r_x[i]} - {C_TGT[16*i+15], C_TGT[16*i +: 16]};
          end
          r_acc   <= '0;
          r_cnt   <= 3'd0;
          r_state <= S_MUL;
        end
        S_MUL: begin
          if (!r_cnt[2]) r_acc <= r_acc + w_sq;
          else           r_p[r_cnt[1:0]] <= w_step;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) r_state <= S_FIN;
        end
        S_FIN: begin
          value      <= w_val_sat;
          a_diff_out <= w_diff_sat[0];
          b_diff_out <= w_diff_sat[1];
          c_diff_out <= w_diff_sat[2];
          d_diff_out <= w_diff_sat[3];
          overflow   <= w_val_ov | (|w_diff_ov);
          func_done  <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_quad4_grad_engine.sv
// +----------------------------------------------------------------------------+
// | tb_quad4_grad_engine: directed bench for quad4_grad_engine                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_quad4_grad_engine;

  logic        clk;
  logic        rst_n;
  logic        start_func;
  logic [15:0] a_in, b_in, c_in, d_in;
  logic [31:0] value, h_value;
  logic [15:0] a_diff_out, b_diff_out, c_diff_out, d_diff_out;
  logic [15:0] h_a_diff, h_b_diff, h_c_diff, h_d_diff;
  logic        func_done, overflow, h_func_done, h_overflow;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;
  int lat;
  int pulses;

  quad4_grad_engine dut (
    .clk(clk), .rst_n(rst_n), .start_func(start_func),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .value(value), .a_diff_out(a_diff_out), .b_diff_out(b_diff_out),
    .c_diff_out(c_diff_out), .d_diff_out(d_diff_out),
    .func_done(func_done), .overflow(overflow)
  );

  quad4_grad_engine #(.LEARNING_RATE(32'h0000_0100)) dut_hi (
    .clk(clk), .rst_n(rst_n), .start_func(start_func),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .value(h_value), .a_diff_out(h_a_diff), .b_diff_out(h_b_diff),
    .c_diff_out(h_c_diff), .d_diff_out(h_d_diff),
    .func_done(h_func_done), .overflow(h_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
    a_in = a; b_in = b; c_in = c; d_in = d;
  endtask

  // Raises start, passes the accept edge, returns edges until func_done (-1 on timeout).
  task automatic launch(output int n_out);
    start_func = 1'b1;
    tick();
    n_out = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (func_done === 1'b1) begin
        n_out = n;
        break;
      end
    end
  endtask

  task automatic check_res(input string tag, input logic [31:0] v,
                           input logic [15:0] ad, input logic [15:0] bd,
                           input logic [15:0] cd, input logic [15:0] dd,
                           input logic ov);
    chk({tag, "_value"}, value, v);
    chk({tag, "_a_diff"}, {16'h0, a_diff_out}, {16'h0, ad});
    chk({tag, "_b_diff"}, {16'h0, b_diff_out}, {16'h0, bd});
    chk({tag, "_c_diff"}, {16'h0, c_diff_out}, {16'h0, cd});
    chk({tag, "_d_diff"}, {16'h0, d_diff_out}, {16'h0, dd});
    chk({tag, "_ovf"}, {31'h0, overflow}, {31'h0, ov});
  endtask

  task automatic count_pulses(input int cycles, output int p);
    p = 0;
    for (int n = 0; n < cycles; n++) begin
      tick();
      if (func_done === 1'b1) p++;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start_func = 1'b0;
    set_ops(16'h0100, 16'hFE00, 16'h0080, 16'h0000);
    tick();
    tick();
    check_res("reset", 32'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    chk("reset_done", {31'h0, func_done}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Operands at targets: zero cost, zero step
    launch(lat);
    chk("t1_latency", 32'(lat), 32'd10);
    check_res("t1", 32'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);

    // One-cycle gap with operand update, then immediate re-accept
    start_func = 1'b0;
    set_ops(16'h0200, 16'hFE00, 16'h0080, 16'h0000);
    tick();
    chk("t1_done_falls", {31'h0, func_done}, 32'h0);
    launch(lat);
    chk("t2_latency", 32'(lat), 32'd10);
    check_res("t2", 32'h0000_0100, 16'h0060, 16'h0, 16'h0, 16'h0, 1'b0);

    // Extreme operands: saturates with LR=1.0, not with LR=0.1875
    start_func = 1'b0;
    set_ops(16'h7FFF, 16'h8000, 16'h0080, 16'h0000);
    tick();
    launch(lat);
    chk("t3_latency", 32'(lat), 32'd10);
    check_res("t3_lr30", 32'h007D_0402, 16'h2F9F, 16'hD0C0, 16'h0, 16'h0, 1'b0);
    chk("t3_hi_value", h_value, 32'h007D_0402);
    chk("t3_hi_a_diff", {16'h0, h_a_diff}, 32'h0000_7FFF);
    chk("t3_hi_b_diff", {16'h0, h_b_diff}, 32'h0000_8000);
    chk("t3_hi_c_diff", {16'h0, h_c_diff}, 32'h0);
    chk("t3_hi_ovf", {31'h0, h_overflow}, 32'h1);

    // start held high: one pulse only; then low one cycle and new operands
    start_func = 1'b0;
    set_ops(16'h0000, 16'hFE00, 16'h0080, 16'h0000);
    tick();
    launch(lat);
    chk("t4_latency", 32'(lat), 32'd10);
    check_res("t4a", 32'h0000_0100, 16'hFFA0, 16'h0, 16'h0, 16'h0, 1'b0);
    count_pulses(25, pulses);
    chk("t4_no_retrigger", 32'(pulses), 32'd0);
    start_func = 1'b0;
    set_ops(16'h0100, 16'hFE00, 16'h0080, 16'hFF80);
    tick();
    launch(lat);
    chk("t4b_latency", 32'(lat), 32'd10);
    check_res("t4b", 32'h0000_0040, 16'h0, 16'h0, 16'h0, 16'hFFD0, 1'b0);

    // Reset at E5 aborts the op
    start_func = 1'b0;
    set_ops(16'h0200, 16'hFE00, 16'h0080, 16'h0000);
    tick();
    start_func = 1'b1;
    tick();
    for (int n = 0; n < 5; n++) tick();
    rst_n      = 1'b0;
    start_func = 1'b0;
    #1;
    check_res("t5_rst", 32'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    tick();
    rst_n = 1'b1;
    count_pulses(15, pulses);
    chk("t5_no_done", 32'(pulses), 32'd0);
    chk("t5_value_held0", value, 32'h0);
    // Sub-LSB negative step truncates toward -inf
    set_ops(16'h00FF, 16'hFE01, 16'h0080, 16'h0000);
    launch(lat);
    chk("t5_latency", 32'(lat), 32'd10);
    check_res("t5", 32'h0, 16'hFFFF, 16'h0000, 16'h0, 16'h0, 1'b0);

    // Rise while busy is ignored; operands changed mid-op have no effect
    start_func = 1'b0;
    set_ops(16'h0200, 16'hFE00, 16'h0080, 16'h0100);
    tick();
    start_func = 1'b1;
    tick();
    tick();
    tick();
    start_func = 1'b0;
    tick();
    start_func = 1'b1;
    set_ops(16'h0100, 16'hFE00, 16'h0080, 16'h0000);
    lat = -1;
    for (int n = 4; n <= 20; n++) begin
      tick();
      if (func_done === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk("t6_latency", 32'(lat), 32'd10);
    check_res("t6", 32'h0000_0200, 16'h0060, 16'h0, 16'h0, 16'h0060, 1'b0);
    count_pulses(15, pulses);
    chk("t6_single_pulse", 32'(pulses), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

`default_nettype wire
